lane_serializer: RTL
====================

LANE_SERIALIZER -- requirements
Module: lane_serializer

Interface
REQ-001 Parameter DATA_W, default 32, input word width in bits.
REQ-002 Parameter LANE_W, default 8, output lane width in bits.
REQ-003 Parameter MSB_FIRST, default 0, lane order: 0 = lane 0 (bits LANE_W-1:0) first, 1 = highest lane first.
REQ-004 Derived constant LANES = DATA_W/LANE_W; IDX_W = max(1, clog2(LANES)).
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  in_data/in_keep valid.
REQ-008 in_ready  output  1  block accepts a word this cycle.
REQ-009 in_data  input  DATA_W  word to serialise.
REQ-010 in_keep  input  LANES  per-lane enable; bit k set = lane k is emitted.
REQ-011 out_valid  output  1  out_data/out_idx/out_last valid.
REQ-012 out_ready  input  1  downstream accepts lane.
REQ-013 out_data  output  LANE_W  lane value, in_data[LANE_W*k +: LANE_W].
REQ-014 out_idx  output  IDX_W  lane index k of out_data.
REQ-015 out_last  output  1  final kept lane of current word.

Function
REQ-016 Input transfer on in_valid & in_ready at a rising edge; output transfer on out_valid & out_ready.
REQ-017 States: IDLE (no word held), SEND (word held, lane presented).
REQ-018 in_ready = 1 in IDLE, or in SEND when out_valid & out_ready & out_last (back-to-back); else 0.
REQ-019 Accepted word with in_keep != 0: capture data/keep, go to SEND, present first kept lane in the cycle after acceptance (latency 1).
REQ-020 Accepted word with in_keep == 0: dropped; state unchanged, no output produced.
REQ-021 Lane order: ascending index when MSB_FIRST=0, descending when 1; lanes with keep bit clear are skipped with zero idle cycles.
REQ-022 out_last = 1 when no further kept lane remains after the presented lane in the chosen order.
REQ-023 out_data, out_idx, out_last registered; held stable while out_valid & !out_ready.
REQ-024 On output transfer with out_last=0: present next kept lane the following cycle, out_valid stays 1.
REQ-025 On output transfer with out_last=1: if a word with nonzero keep is accepted the same edge, present its first lane next cycle (stay SEND); otherwise go to IDLE, out_valid = 0.
REQ-026 in_data/in_keep changes while in_ready=0 have no effect.
REQ-027 Elaboration error if DATA_W % LANE_W != 0 or LANES < 2.

Reset
REQ-028 While rst=1: state IDLE, out_valid=0, out_data=0, out_idx=0, out_last=0, in_ready=0, captured word and keep cleared.
REQ-029 rst asserted mid-word discards remaining lanes; after deassertion in_ready=1 and no residual lane is emitted.

Structure
REQ-030 Package lane_ser_pkg holds the state enum (IDLE, SEND) and the LANES/IDX_W derivation functions.
REQ-031 One sub-module lane_pick: combinational, given keep mask, current index and MSB_FIRST, returns next kept index and a found flag; used for both first-lane and next-lane selection.

Verification
REQ-032 DATA_W=32, LANE_W=8, MSB_FIRST=0, in_data=32'hFACE_CAFE, keep=4'b1111, out_ready=1 -> FE/0, CA/1, CE/2, FA/3 on consecutive cycles, out_last only on FA.
REQ-033 Same word, MSB_FIRST=1 -> FA/3, CE/2, CA/1, FE/0, out_last on FE.
REQ-034 keep=4'b0101 -> FE/0 then CE/2 (last) in two consecutive cycles; keep=4'b0000 -> no out_valid, in_ready remains 1.
REQ-035 out_ready held 0 for 3 cycles while CA/1 presented -> out_data=CA, out_idx=1 stable throughout, then CE/2 the cycle after out_ready=1.
REQ-036 Two words (32'hFACE_CAFE then 32'h1234_5678, keep all ones) offered back-to-back -> 8 consecutive output beats with no bubble, second word starting 78/0.
REQ-037 rst pulsed after CA/1 transfers -> out_valid=0 immediately; after release in_ready=1, next output is first lane of the next accepted word.

Source files
------------

// File: rtl/lane_ser_pkg.sv
// Shared types and elaboration-time helpers for the lane serializer.
package lane_ser_pkg;

    typedef enum logic {IDLE, SEND} state_t;

    function automatic int lanes_of(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

    function automatic int idx_w_of(input int lanes);
        return (lanes > 2) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/lane_serializer_lane_pick.sv
// Finds the next kept lane at or after (incl=1) / strictly after (incl=0) cur,
// walking ascending or descending depending on MSB_FIRST.
module lane_pick #(
    parameter int LANES     = 4,
    parameter int IDX_W     = 2,
    parameter int MSB_FIRST = 0
) (
    input  logic [LANES-1:0] keep,
    input  logic [IDX_W-1:0] cur,
    input  logic             incl,
    output logic [IDX_W-1:0] nxt,
    output logic             found
);

    // Scan opposite to the lane order so the last hit is the nearest kept lane.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < LANES; i++) begin
                if (keep[i] && (i < int'(cur) || (incl && i == int'(cur)))) begin
                    nxt   = IDX_W'(i);
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = LANES - 1; i >= 0; i--) begin
                if (keep[i] && (i > int'(cur) || (incl && i == int'(cur)))) begin
                    nxt   = IDX_W'(i);
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lane_serializer.sv
// Serialises a DATA_W word into LANE_W lanes, skipping lanes whose keep bit is
// clear, with back-to-back word acceptance on the final lane.
module lane_serializer
    import lane_ser_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int LANE_W    = 8,
    parameter int MSB_FIRST = 0,
    localparam int LANES    = lanes_of(DATA_W, LANE_W),
    localparam int IDX_W    = idx_w_of(LANES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [LANES-1:0]  in_keep,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last
);

    if (DATA_W % LANE_W != 0 || LANES < 2) begin : g_bad_params
        $error("lane_serializer: DATA_W must be a multiple of LANE_W with at least 2 lanes");
    end

    localparam logic [IDX_W-1:0] START_IDX = (MSB_FIRST != 0) ? IDX_W'(LANES - 1) : '0;

    state_t             state;
    logic [DATA_W-1:0]  data_q;
    logic [LANES-1:0]   keep_q;
    logic [IDX_W-1:0]   nxt_q;

    logic               out_fire, in_fire, load, advance;
    logic [DATA_W-1:0]  sel_data;
    logic [LANES-1:0]   sel_keep;
    logic [IDX_W-1:0]   sel_cur, pick_idx, tail_idx;
    logic               pick_found, tail_found;

    assign out_fire = out_valid & out_ready;
    assign in_ready = !rst && (state == IDLE || (out_fire && out_last));
    assign in_fire  = in_valid & in_ready;

    // A newly accepted word searches from its first lane; otherwise resume
    // from the lookahead index stored when the current lane was presented.
    assign sel_data = in_fire ? in_data : data_q;
    assign sel_keep = in_fire ? in_keep : keep_q;
    assign sel_cur  = in_fire ? START_IDX : nxt_q;

    assign load     = in_fire & pick_found;
    assign advance  = out_fire & !out_last;

    lane_pick #(.LANES(LANES), .IDX_W(IDX_W), .MSB_FIRST(MSB_FIRST)) u_pick (
        .keep  (sel_keep),
        .cur   (sel_cur),
        .incl  (1'b1),
        .nxt   (pick_idx),
        .found (pick_found)
    );

    // Lookahead past the lane being presented: drives out_last and the next search.
    lane_pick #(.LANES(LANES), .IDX_W(IDX_W), .MSB_FIRST(MSB_FIRST)) u_tail (
        .keep  (sel_keep),
        .cur   (pick_idx),
        .incl  (1'b0),
        .nxt   (tail_idx),
        .found (tail_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            data_q    <= '0;
            keep_q    <= '0;
            nxt_q     <= '0;
        end else if (load || advance) begin
            state     <= SEND;
            out_valid <= 1'b1;
            out_data  <= sel_data[int'(pick_idx)*LANE_W +: LANE_W];
            out_idx   <= pick_idx;
            out_last  <= !tail_found;
            nxt_q     <= tail_idx;
            if (load) begin
                data_q <= in_data;
                keep_q <= in_keep;
            end
        end else if (out_fire) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end
    end

endmodule
